// File: rtl/mux_en_sync_rx_pkg.sv
// Shared definitions for the mux-enable synchronizer receiver.
//   state_t            : per-channel handshake state
//   MIN_/MAX_STAGES    : legal range for the req synchronizer depth
//   stages_legal()     : range check used at elaboration
package mux_en_sync_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;

  function automatic bit stages_legal(input int stages);
    return (stages >= MIN_STAGES) && (stages <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/mux_en_sync_rx_ch.sv
// One receive channel: req synchronizer, toggle edge detect, handshake FSM,
// mux-enable holding register, ack toggle flop and sticky overrun flag.
// Ports:
//   clk, rst        : destination clock, synchronous active-high reset
//   async_req       : req toggle from source domain (asynchronous)
//   async_data      : quasi-static source data, captured only on req edge
//   async_ack       : ack toggle back to source, registered
//   dout_valid/data : held word and its valid flag
//   dout_ready      : consumer accept
//   err, err_clr    : sticky overrun flag and its clear
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no word held; waiting for a req toggle
// HOLD  | word held and presented; waiting for dout_ready
module mux_en_sync_rx_ch
  import mux_en_sync_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             async_req,
  input  logic [WIDTH-1:0] async_data,
  output logic             async_ack,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout_data,
  input  logic             dout_ready,
  output logic             err,
  input  logic             err_clr
);

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("mux_en_sync_rx_ch: STAGES must lie between MIN_STAGES and MAX_STAGES");
  end

  logic [STAGES-1:0] sync_q;
  logic              req_d;
  logic              req_s;
  logic              req_edge;
  state_t            state;

  assign req_s    = sync_q[STAGES-1];
  assign req_edge = req_s ^ req_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      req_d      <= 1'b0;
      state      <= IDLE;
      async_ack  <= 1'b0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      err        <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_req};
      req_d  <= req_s;

      unique case (state)
        IDLE: begin
          // async_data is stable while the toggle is in flight, so the
          // edge-qualified load is the only crossing point for the bus.
          if (req_edge) begin
            dout_data  <= async_data;
            dout_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            async_ack  <= ~async_ack;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A new request while a word is still held is an overrun; it is never
      // captured, and the set takes priority over a same-cycle clear.
      if ((state == HOLD) && req_edge) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_en_sync_rx.sv
// Multi-channel destination-domain receiver for toggle req/ack mux-enable
// data crossings. Each channel is an independent mux_en_sync_rx_ch.
// Ports:
//   clk, rst    : destination clock, synchronous active-high reset
//   async_req   : [CHANNELS] req toggles from the source domain
//   async_data  : [CHANNELS*WIDTH] source data, channel c at [c*WIDTH +: WIDTH]
//   async_ack   : [CHANNELS] registered ack toggles to the source domain
//   dout_valid  : [CHANNELS] held word available
//   dout_data   : [CHANNELS*WIDTH] held words, same packing as async_data
//   dout_ready  : [CHANNELS] consumer accepts word
//   err         : [CHANNELS] sticky overrun flags
//   err_clr     : clears all err bits
module mux_en_sync_rx
  import mux_en_sync_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int STAGES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       async_req,
  input  logic [CHANNELS*WIDTH-1:0] async_data,
  output logic [CHANNELS-1:0]       async_ack,
  output logic [CHANNELS-1:0]       dout_valid,
  output logic [CHANNELS*WIDTH-1:0] dout_data,
  input  logic [CHANNELS-1:0]       dout_ready,
  output logic [CHANNELS-1:0]       err,
  input  logic                      err_clr
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mux_en_sync_rx_ch #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .async_req  (async_req[c]),
      .async_data (async_data[c*WIDTH +: WIDTH]),
      .async_ack  (async_ack[c]),
      .dout_valid (dout_valid[c]),
      .dout_data  (dout_data[c*WIDTH +: WIDTH]),
      .dout_ready (dout_ready[c]),
      .err        (err[c]),
      .err_clr    (err_clr)
    );
  end

endmodule

// File: tb/tb_mux_en_sync_rx.sv
module tb_mux_en_sync_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        err_clr;

  // instance a: WIDTH=8, STAGES=2 ; instance b: WIDTH=16, STAGES=4
  logic [1:0]  req_a, ready_a, ack_a, valid_a, err_a;
  logic [15:0] data_a, dout_a;
  logic [1:0]  req_b, ready_b, ack_b, valid_b, err_b;
  logic [31:0] data_b, dout_b;

  mux_en_sync_rx #(.WIDTH(8), .CHANNELS(2), .STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .async_req(req_a), .async_data(data_a),
    .async_ack(ack_a), .dout_valid(valid_a), .dout_data(dout_a),
    .dout_ready(ready_a), .err(err_a), .err_clr(err_clr)
  );

  mux_en_sync_rx #(.WIDTH(16), .CHANNELS(2), .STAGES(4)) dut_b (
    .clk(clk), .rst(rst), .async_req(req_b), .async_data(data_b),
    .async_ack(ack_b), .dout_valid(valid_b), .dout_data(dout_b),
    .dout_ready(ready_b), .err(err_b), .err_clr(err_clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a request toggle sampled at cycle k is seen by the
  // channel at cycle k+STAGES; req history is kept as a list of samples.
  logic [7:0]  m_hist  [2][2];
  logic        m_valid [2][2];
  logic        m_ack   [2][2];
  logic        m_err   [2][2];
  logic [15:0] m_data  [2][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        automatic int          s  = (i == 0) ? 2 : 4;
        automatic logic        rq = (i == 0) ? req_a[c] : req_b[c];
        automatic logic        rd = (i == 0) ? ready_a[c] : ready_b[c];
        automatic logic [15:0] dw = (i == 0) ? 16'(data_a[c*8 +: 8]) : data_b[c*16 +: 16];
        automatic logic        arrived;
        automatic logic        overrun = 1'b0;
        if (rst) begin
          m_hist[i][c]  = '0;
          m_valid[i][c] = 1'b0;
          m_ack[i][c]   = 1'b0;
          m_err[i][c]   = 1'b0;
          m_data[i][c]  = '0;
        end else begin
          m_hist[i][c] = {m_hist[i][c][6:0], rq};
          arrived = m_hist[i][c][s] ^ m_hist[i][c][s+1];
          if (!m_valid[i][c]) begin
            if (arrived) begin
              m_valid[i][c] = 1'b1;
              m_data[i][c]  = dw;
            end
          end else begin
            overrun = arrived;
            if (rd) begin
              m_valid[i][c] = 1'b0;
              m_ack[i][c]   = ~m_ack[i][c];
            end
          end
          if (overrun) m_err[i][c] = 1'b1;
          else if (err_clr) m_err[i][c] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("valid i%0d c%0d", i, c), 32'((i == 0) ? valid_a[c] : valid_b[c]), 32'(m_valid[i][c]));
        chk($sformatf("ack i%0d c%0d", i, c),   32'((i == 0) ? ack_a[c] : ack_b[c]),     32'(m_ack[i][c]));
        chk($sformatf("err i%0d c%0d", i, c),   32'((i == 0) ? err_a[c] : err_b[c]),     32'(m_err[i][c]));
        chk($sformatf("data i%0d c%0d", i, c),
            (i == 0) ? 32'(dout_a[c*8 +: 8]) : 32'(dout_b[c*16 +: 16]), 32'(m_data[i][c]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid_b0(input string tag);
    int n = 0;
    while (valid_b[0] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(valid_b[0]), 32'd1);
  endtask

  initial begin
    logic [1:0] ack_prev;
    rst = 1'b1; err_clr = 1'b0;
    req_a = '0; ready_a = '0; data_a = '0;
    req_b = '0; ready_b = '0; data_b = '0;
    steps(2);
    chk("reset_valid_a", 32'(valid_a), 32'd0);
    chk("reset_data_a", 32'(dout_a), 32'd0);
    rst = 1'b0;

    // basic transfer, STAGES=2
    data_a[7:0] = 8'hA5; req_a[0] = 1'b1;
    steps(2);
    chk("t1_valid_early", 32'(valid_a[0]), 32'd0);
    step();
    chk("t1_valid", 32'(valid_a[0]), 32'd1);
    chk("t1_data", 32'(dout_a[7:0]), 32'hA5);
    ready_a[0] = 1'b1; step(); ready_a[0] = 1'b0;
    chk("t1_ack", 32'(ack_a[0]), 32'd1);
    chk("t1_valid_clr", 32'(valid_a[0]), 32'd0);

    // back-pressure
    req_a[0] = 1'b0;
    steps(3);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t2_hold_valid", 32'(valid_a[0]), 32'd1);
      chk("t2_hold_data", 32'(dout_a[7:0]), 32'hA5);
      chk("t2_hold_ack", 32'(ack_a[0]), 32'd1);
    end
    ready_a[0] = 1'b1; step(); ready_a[0] = 1'b0;
    chk("t2_ack_toggle", 32'(ack_a[0]), 32'd0);

    // overrun, then overrun with concurrent clear
    req_a[0] = 1'b1; steps(3);
    data_a[7:0] = 8'h3C; req_a[0] = 1'b0; steps(3);
    chk("t3_err_set", 32'(err_a[0]), 32'd1);
    chk("t3_data_kept", 32'(dout_a[7:0]), 32'hA5);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t3_err_clr", 32'(err_a[0]), 32'd0);
    data_a[7:0] = 8'h77; req_a[0] = 1'b1; steps(2);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t3_set_wins", 32'(err_a[0]), 32'd1);
    chk("t3_data_kept2", 32'(dout_a[7:0]), 32'hA5);
    ready_a[0] = 1'b1; step(); ready_a[0] = 1'b0;
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // both channels at once
    data_a = 16'h2211; req_a = ~req_a;
    steps(3);
    chk("t4_valid_both", 32'(valid_a), 32'd3);
    chk("t4_data_both", 32'(dout_a), 32'h2211);
    ack_prev = ack_a;
    ready_a = 2'b10; step(); ready_a = 2'b00;
    chk("t4_ack_ch1_only", 32'(ack_a), 32'(ack_prev ^ 2'b10));
    ready_a = 2'b01; step(); ready_a = 2'b00;

    // reset mid-transfer
    data_a[7:0] = 8'h5A; req_a[0] = ~req_a[0]; steps(3);
    chk("t5_hold", 32'(valid_a[0]), 32'd1);
    rst = 1'b1; req_a = '0; data_a = '0; step(); rst = 1'b0;
    chk("t5_valid", 32'(valid_a), 32'd0);
    chk("t5_data", 32'(dout_a), 32'd0);
    chk("t5_ack", 32'(ack_a), 32'd0);
    chk("t5_err", 32'(err_a), 32'd0);
    data_a[7:0] = 8'hC3; req_a[0] = 1'b1; steps(2);
    chk("t5_fresh_early", 32'(valid_a[0]), 32'd0);
    step();
    chk("t5_fresh_data", 32'(dout_a[7:0]), 32'hC3);
    ready_a[0] = 1'b1; step(); ready_a[0] = 1'b0;
    chk("t5_fresh_ack", 32'(ack_a[0]), 32'd1);

    // STAGES=4, WIDTH=16
    data_b[15:0] = 16'hBEEF; req_b[0] = 1'b1;
    steps(4);
    chk("t6_valid_early", 32'(valid_b[0]), 32'd0);
    step();
    chk("t6_valid", 32'(valid_b[0]), 32'd1);
    chk("t6_data", 32'(dout_b[15:0]), 32'hBEEF);
    ready_b[0] = 1'b1; step(); ready_b[0] = 1'b0;
    chk("t6_ack", 32'(ack_b[0]), 32'd1);
    data_b[15:0] = 16'h1234; req_b[0] = 1'b0;
    wait_valid_b0("t6_wait_w1");
    chk("t6_w1", 32'(dout_b[15:0]), 32'h1234);
    ready_b[0] = 1'b1; step(); ready_b[0] = 1'b0;
    chk("t6_ack_w1", 32'(ack_b[0]), 32'd0);
    data_b[15:0] = 16'h5678; req_b[0] = 1'b1;
    wait_valid_b0("t6_wait_w2");
    chk("t6_w2", 32'(dout_b[15:0]), 32'h5678);
    ready_b[0] = 1'b1; step(); ready_b[0] = 1'b0;
    chk("t6_ack_w2", 32'(ack_b[0]), 32'd1);
    chk("t6_err", 32'(err_b[0]), 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rst     = ($urandom_range(199) == 0);
      err_clr = ($urandom_range(15) == 0);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(7) == 0) begin
          req_a[c] = ~req_a[c];
          data_a[c*8 +: 8] = 8'($urandom);
        end
        if ($urandom_range(7) == 0) begin
          req_b[c] = ~req_b[c];
          data_b[c*16 +: 16] = 16'($urandom);
        end
        ready_a[c] = 1'($urandom);
        ready_b[c] = 1'($urandom);
      end
      if (rst) begin
        req_a = '0;
        req_b = '0;
      end
      step();
    end
    rst = 1'b0; err_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
